// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the frame-buffer port between VGA fetch (priority) and CPU,
// with a bounded-wait guard for the CPU and a saturating count of dropped VGA fetches.
module fb_port_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_pixel,
  output logic              vga_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic [15:0]       vga_miss_cnt
);
  logic              force_cpu, cpu_own, vga_own, vga_drop;
  logic [7:0]        wait_cnt_d, wait_cnt_q;
  logic [2:0]        tag_d, tag_q;
  logic [DATA_W-1:0] vga_pixel_d, vga_pixel_q, cpu_rdata_d, cpu_rdata_q;
  logic              vga_valid_d, vga_valid_q, cpu_rvalid_d, cpu_rvalid_q;
  logic [15:0]       miss_cnt_d, miss_cnt_q;
  always_comb begin
    force_cpu    = cpu_req && wait_cnt_q == 8'(MAX_WAIT);
    cpu_own      = cpu_req && (force_cpu || !vga_req);
    vga_own      = vga_req && !force_cpu;
    vga_drop     = vga_req && force_cpu;
    cpu_gnt      = rst_n && cpu_own;
    mem_addr     = cpu_own ? cpu_addr : vga_own ? vga_addr : '0;
    mem_we       = cpu_own && cpu_we;
    mem_wdata    = cpu_own ? cpu_wdata : '0;
    wait_cnt_d   = (cpu_own || !cpu_req) ? 8'd0 : wait_cnt_q + 8'd1;
    // tag = {vga_rd, vga_drop, cpu_rd}; a dropped fetch still yields a valid pulse
    tag_d        = {vga_own, vga_drop, cpu_own && !cpu_we};
    vga_pixel_d  = tag_q[2] ? mem_q : vga_pixel_q;
    vga_valid_d  = tag_q[2] || tag_q[1];
    cpu_rdata_d  = tag_q[0] ? mem_q : cpu_rdata_q;
    cpu_rvalid_d = tag_q[0];
    miss_cnt_d   = (vga_drop && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      tag_q        <= '0;
      vga_pixel_q  <= '0;
      vga_valid_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      tag_q        <= tag_d;
      vga_pixel_q  <= vga_pixel_d;
      vga_valid_q  <= vga_valid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end
  assign vga_pixel    = vga_pixel_q;
  assign vga_valid    = vga_valid_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign vga_miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed tests of the frame-buffer arbiter, one task per scenario,
// with a behavioural one-cycle-latency RAM behind the main instance.
module tb_fb_port_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        vga_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [18:0] vga_addr = '0, cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  vga_pixel, cpu_rdata, mem_wdata, mem_q;
  logic        vga_valid, cpu_gnt, cpu_rvalid, mem_we;
  logic [18:0] mem_addr;
  logic [15:0] vga_miss_cnt;
  logic        b_vga_req = 1'b0, b_cpu_req = 1'b0;
  logic [7:0]  b_pixel, b_rdata, b_wdata;
  logic        b_valid, b_gnt, b_rvalid, b_we;
  logic [18:0] b_addr;
  logic [15:0] b_miss;
  logic [7:0]  b_mem_q;
  logic [7:0]  ram [0:524287];
  bit          written [0:524287];
  int          nvec = 0, nerr = 0;

  assign b_mem_q = 8'h00;
  always #5 clk = ~clk;

  // Unwritten locations read as addr[7:0]+8'h10
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_q <= written[mem_addr] ? ram[mem_addr] : mem_addr[7:0] + 8'h10;
  end

  fb_port_arbiter #(.ADDR_W(19), .DATA_W(8), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_pixel(vga_pixel), .vga_valid(vga_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_q(mem_q), .vga_miss_cnt(vga_miss_cnt));

  fb_port_arbiter #(.ADDR_W(19), .DATA_W(8), .MAX_WAIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .vga_req(b_vga_req), .vga_addr(vga_addr),
    .vga_pixel(b_pixel), .vga_valid(b_valid), .cpu_req(b_cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(b_gnt), .cpu_rdata(b_rdata),
    .cpu_rvalid(b_rvalid), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we),
    .mem_q(b_mem_q), .vga_miss_cnt(b_miss));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    cpu_req = 1'b1; cpu_addr = 19'h5;
    #1;
    nvec++; if (cpu_gnt !== 1'b0) begin nerr++; $display("FAIL reset_gnt: got %b expected 0", cpu_gnt); end
    nvec++; if (mem_addr !== 19'h5) begin nerr++; $display("FAIL reset_mem_addr: got %h expected 00005", mem_addr); end
    nvec++; if ({vga_pixel, vga_valid, cpu_rdata, cpu_rvalid, vga_miss_cnt} !== '0) begin
      nerr++; $display("FAIL reset_outs: got %h %b %h %b %h expected all 0", vga_pixel, vga_valid, cpu_rdata, cpu_rvalid, vga_miss_cnt);
    end
    cpu_req = 1'b0; cpu_addr = '0;
    cyc; cyc;
    rst_n = 1'b1;
  endtask

  task automatic test_vga_only;
    for (int i = 0; i < 6; i++) begin
      vga_req = i < 3; vga_addr = 19'(i);
      #1;
      nvec++; if (cpu_gnt !== 1'b0) begin nerr++; $display("FAIL vga_only_gnt c%0d: got %b expected 0", i, cpu_gnt); end
      if (i < 3) begin
        nvec++; if (mem_addr !== 19'(i)) begin nerr++; $display("FAIL vga_only_addr c%0d: got %h expected %h", i, mem_addr, 19'(i)); end
      end
      nvec++; if (vga_valid !== (i >= 2 && i <= 4)) begin nerr++; $display("FAIL vga_only_valid c%0d: got %b", i, vga_valid); end
      if (i >= 2 && i <= 4) begin
        nvec++; if (vga_pixel !== 8'h10 + 8'(i - 2)) begin nerr++; $display("FAIL vga_only_pixel c%0d: got %h expected %h", i, vga_pixel, 8'h10 + 8'(i - 2)); end
      end
      cyc;
    end
  endtask

  task automatic test_cpu_wr_rd;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h12C00; cpu_wdata = 8'hA5;
    #1;
    nvec++; if ({cpu_gnt, mem_we} !== 2'b11) begin nerr++; $display("FAIL wr_gnt_we: got %b%b expected 11", cpu_gnt, mem_we); end
    nvec++; if ({mem_addr, mem_wdata} !== {19'h12C00, 8'hA5}) begin nerr++; $display("FAIL wr_port: got %h %h expected 12c00 a5", mem_addr, mem_wdata); end
    cyc;
    cpu_we = 1'b0; cpu_wdata = 8'h00;
    #1;
    nvec++; if ({cpu_gnt, mem_we} !== 2'b10) begin nerr++; $display("FAIL rd_gnt_we: got %b%b expected 10", cpu_gnt, mem_we); end
    cyc;
    cpu_req = 1'b0;
    #1;
    nvec++; if (cpu_rvalid !== 1'b0) begin nerr++; $display("FAIL wr_no_rvalid: got %b expected 0", cpu_rvalid); end
    cyc;
    nvec++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hA5}) begin nerr++; $display("FAIL rd_data: got %b %h expected 1 a5", cpu_rvalid, cpu_rdata); end
    cyc;
    nvec++; if (cpu_rvalid !== 1'b0) begin nerr++; $display("FAIL rd_pulse: got %b expected 0", cpu_rvalid); end
  endtask

  task automatic test_contention;
    logic [7:0] ep;
    for (int i = 0; i < 20; i++) begin
      vga_req = 1'b1; vga_addr = 19'h30 + 19'(i);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h12C00;
      #1;
      nvec++; if (cpu_gnt !== (i == 8 || i == 17)) begin nerr++; $display("FAIL cont_gnt c%0d: got %b", i, cpu_gnt); end
      nvec++; if (vga_valid !== (i >= 2)) begin nerr++; $display("FAIL cont_valid c%0d: got %b", i, vga_valid); end
      if (i >= 2) begin
        ep = 8'h40 + 8'(i - 2) - ((i == 10 || i == 19) ? 8'd1 : 8'd0);
        nvec++; if (vga_pixel !== ep) begin nerr++; $display("FAIL cont_pixel c%0d: got %h expected %h", i, vga_pixel, ep); end
      end
      nvec++; if (cpu_rvalid !== (i == 10 || i == 19)) begin nerr++; $display("FAIL cont_rvalid c%0d: got %b", i, cpu_rvalid); end
      if (i == 10) begin
        nvec++; if (cpu_rdata !== 8'hA5) begin nerr++; $display("FAIL cont_rdata: got %h expected a5", cpu_rdata); end
      end
      if (i == 9) begin
        nvec++; if (vga_miss_cnt !== 16'd1) begin nerr++; $display("FAIL cont_miss1: got %0d expected 1", vga_miss_cnt); end
      end
      cyc;
    end
    vga_req = 1'b0; cpu_req = 1'b0;
    #1;
    nvec++; if (vga_miss_cnt !== 16'd2) begin nerr++; $display("FAIL cont_miss2: got %0d expected 2", vga_miss_cnt); end
  endtask

  task automatic test_reset_mid_read;
    cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h12C00;
    #1;
    nvec++; if (cpu_gnt !== 1'b1) begin nerr++; $display("FAIL rst_rd_gnt: got %b expected 1", cpu_gnt); end
    cyc;
    rst_n = 1'b0;
    #1;
    nvec++; if (cpu_gnt !== 1'b0) begin nerr++; $display("FAIL rst_gnt_mask: got %b expected 0", cpu_gnt); end
    nvec++; if ({vga_pixel, vga_valid, cpu_rdata, cpu_rvalid, vga_miss_cnt} !== '0) begin
      nerr++; $display("FAIL rst_mid_outs: got %h %b %h %b %h expected all 0", vga_pixel, vga_valid, cpu_rdata, cpu_rvalid, vga_miss_cnt);
    end
    cyc;
    rst_n = 1'b1; cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      nvec++; if ({cpu_rvalid, vga_valid} !== 2'b00) begin nerr++; $display("FAIL rst_no_valid c%0d: got %b%b expected 00", i, cpu_rvalid, vga_valid); end
      cyc;
    end
  endtask

  task automatic test_idle;
    vga_addr = 19'h5; cpu_addr = 19'h12C00; cpu_wdata = 8'h3C; cpu_we = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      nvec++; if ({mem_we, mem_addr, mem_wdata} !== '0) begin nerr++; $display("FAIL idle_port c%0d: got %b %h %h expected 0", i, mem_we, mem_addr, mem_wdata); end
      nvec++; if ({vga_valid, cpu_rvalid, cpu_gnt} !== 3'b000) begin nerr++; $display("FAIL idle_valid c%0d: got %b%b%b", i, vga_valid, cpu_rvalid, cpu_gnt); end
      nvec++; if (dut.wait_cnt_q !== 8'd0) begin nerr++; $display("FAIL idle_wait c%0d: got %0d expected 0", i, dut.wait_cnt_q); end
      cyc;
    end
    cpu_we = 1'b0;
  endtask

  task automatic test_alternate_saturate;
    logic [16:0] em;
    for (int i = 0; i < 6; i++) begin
      b_vga_req = 1'b1; b_cpu_req = 1'b1;
      #1;
      nvec++; if (b_gnt !== (i % 2 == 1)) begin nerr++; $display("FAIL alt_gnt c%0d: got %b", i, b_gnt); end
      cyc;
    end
    b_vga_req = 1'b0; b_cpu_req = 1'b0;
    #1;
    nvec++; if (b_miss !== 16'd3) begin nerr++; $display("FAIL alt_miss: got %0d expected 3", b_miss); end
    force dut_b.miss_cnt_q = 16'hFFFD;
    #1;
    release dut_b.miss_cnt_q;
    cyc;
    for (int i = 0; i < 8; i++) begin
      b_vga_req = 1'b1; b_cpu_req = 1'b1;
      #1;
      em = 17'hFFFD + 17'(i / 2);
      if (em > 17'hFFFF) em = 17'hFFFF;
      nvec++; if (b_miss !== em[15:0]) begin nerr++; $display("FAIL sat_miss c%0d: got %h expected %h", i, b_miss, em[15:0]); end
      cyc;
    end
    b_vga_req = 1'b0; b_cpu_req = 1'b0;
    #1;
    nvec++; if (b_miss !== 16'hFFFF) begin nerr++; $display("FAIL sat_hold: got %h expected ffff", b_miss); end
  endtask

  initial begin
    test_reset;
    test_vga_only;
    test_cpu_wr_rd;
    test_contention;
    test_reset_mid_read;
    test_idle;
    test_alternate_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares the single read/write port of the 640×480×8 frame buffer between the VGA pixel fetch path and the CPU pipeline's memory-mapped frame-buffer accesses. The VGA fetch path has fixed priority. A bounded-wait guard keeps the CPU from starving, and the block counts the pixels dropped when that guard fires. It sits between the VGA top level (pixel address/data) and the frame-buffer RAM, with the CPU data-memory decoder as the second requester.

## Interface
Parameters:
- ADDR_W, 19, frame-buffer address width
- DATA_W, 8, pixel width
- MAX_WAIT, 8, number of consecutive denied CPU cycles before the CPU is forced through (1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- vga_req  in  1  VGA fetch request this cycle
- vga_addr  in  ADDR_W  VGA pixel address
- vga_pixel  out  DATA_W  returned pixel, registered
- vga_valid  out  1  vga_pixel valid (one-cycle pulse)
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- cpu_rdata  out  DATA_W  CPU read data, registered
- cpu_rvalid  out  1  cpu_rdata valid (one-cycle pulse)
- mem_addr  out  ADDR_W  RAM address (combinational)
- mem_wdata  out  DATA_W  RAM write data (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_q  in  DATA_W  RAM read data, valid one cycle after address
- vga_miss_cnt  out  16  saturating count of dropped VGA fetches

## Operation
Grant decision is made each cycle N with the following priority:
- **FORCE_CPU:** cpu_req and wait_cnt == MAX_WAIT.
  - CPU owns the port and cpu_gnt=1.
  - If vga_req is also high, the VGA fetch is dropped and vga_miss_cnt increments. It saturates at 16'hFFFF.
- **VGA:** vga_req, no force. VGA owns the port; if cpu_req is high, wait_cnt increments.
- **CPU:** cpu_req and !vga_req. CPU owns the port and cpu_gnt=1.
- **IDLE:** no requests. Outputs are mem_addr=0, mem_we=0, mem_wdata=0.

Port drive per owner:
- VGA owner: mem_addr=vga_addr, mem_we=0.
- CPU owner: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.

wait_cnt (8 bit) behaviour:
- Clears on any cycle with cpu_gnt=1 or cpu_req=0.
- Never exceeds MAX_WAIT.

Return pipeline (a 2-stage tag shift carrying {vga_rd, vga_drop, cpu_rd}):
- **Cycle N+1:** mem_q is sampled into the output register of the tagged owner.
- **Cycle N+2:** vga_valid or cpu_rvalid pulses high.
- **Dropped VGA fetch:** vga_valid still pulses at N+2, so pixel cadence is preserved, and vga_pixel repeats its previous value.
- **CPU writes:** produce no cpu_rvalid.

CPU handshake:
- The CPU holds cpu_req/we/addr/wdata stable until it sees cpu_gnt=1.
- It may present a new request in cycle N+1.
- The CPU may have multiple reads outstanding; cpu_rvalid returns them in order.

## Timing
- **Reset (async assert, sync release):**
  - vga_pixel=0, vga_valid=0, cpu_rdata=0, cpu_rvalid=0, vga_miss_cnt=0, wait_cnt=0.
  - Pipeline tags are cleared.
  - Combinational mem_*/cpu_gnt follow the inputs, but cpu_gnt is forced to 0 while rst_n=0.
- **Reset mid-operation:** in-flight reads are discarded. No valid pulse follows reset release unless a new request is made.
- **Read latency:** 2 cycles from request cycle to valid pulse, for both requesters.
- **Throughput:** one access per cycle, and back-to-back grants are allowed.
- **Boundary — continuous VGA:** with vga_req held high, exactly one CPU access completes every MAX_WAIT+1 cycles.
- **Boundary — MAX_WAIT=1:** the CPU and VGA alternate.
- **vga_miss_cnt:** holds at 16'hFFFF once saturated, until reset.
- **Simultaneous cpu_req drop and force:** force applies only if cpu_req is high in that cycle.

## Test plan
- **VGA only:** vga_req=1 with addresses 0,1,2 and RAM preloaded 8'h10,8'h11,8'h12 -> vga_valid high in cycles 2,3,4 with vga_pixel 10,11,12; cpu_gnt=0.
- **CPU write then read:**
  - Stimulus: write 8'hA5 to 19'h12C00, then a read from 19'h12C00.
  - Required: cpu_gnt=1 in both cycles, mem_we=1 in the first only, cpu_rvalid two cycles after the read grant with cpu_rdata=A5.
- **Contention, MAX_WAIT=8:**
  - Stimulus: vga_req held high; cpu_req (read) raised at cycle 0.
  - Required: cpu_gnt in cycle 8; VGA fetch dropped; vga_valid at cycle 10 repeats the cycle-9 pixel; vga_miss_cnt=1.
- **Saturation:** preload vga_miss_cnt path by forcing 65 536 drops (MAX_WAIT=1, both requesting) -> counter reads FFFF and stays FFFF after further drops.
- **Async reset mid-read:** read granted at cycle 0, rst_n low at cycle 1 for 1 cycle -> cpu_rvalid never asserts; all outputs 0 during reset.
- **Idle:** no requests for 20 cycles -> mem_we=0, mem_addr=0, no valid pulses, wait_cnt stays 0.
